stopwatch_counter: RTL and testbench

//  Upstream source for the 4-digit seven-segment scan stage. Produces a 4-digit BCD stopwatch value
//  (SS.cc, hundredths of a second) on count[15:0] and the free-running clk_1k scan clock that stage consumes.

---
 rtl/stopwatch_counter.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// BCD stopwatch (SS.cc) with synchronized start/stop and clear buttons,
// plus a free-running square-wave scan clock for the display multiplexer.
module stopwatch_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_ss,
    input  logic        btn_clr,
    output logic [15:0] count,
    output logic        clk_1k,
    output logic        running,
    output logic        overflow,
    output logic [1:0]  state_dbg
);

    localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int SCAN_HALF = SCAN_DIV / 2;
    localparam int TICK_W    = $clog2(TICK_DIV);
    localparam int SCAN_W    = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_HALF - 1);
    localparam logic [15:0]       COUNT_MAX = 16'h9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic               running_q, overflow_q;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic               clk_1k_q, clk_1k_d;

    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic clr_meta_q, clr_sync_q, clr_prev_q;
    logic ss_p, clr_p, tick;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchronizer followed by a previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_meta_q  <= 1'b0;
            ss_sync_q  <= 1'b0;
            ss_prev_q  <= 1'b0;
            clr_meta_q <= 1'b0;
            clr_sync_q <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            ss_meta_q  <= btn_ss;
            ss_sync_q  <= ss_meta_q;
            ss_prev_q  <= ss_sync_q;
            clr_meta_q <= btn_clr;
            clr_sync_q <= clr_meta_q;
            clr_prev_q <= clr_sync_q;
        end
    end

    always_comb begin
        ss_p  = ss_sync_q & ~ss_prev_q;
        clr_p = clr_sync_q & ~clr_prev_q;
        tick  = (state_q == RUN) && (presc_q == TICK_LAST);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        if (clr_p) begin
            state_d = IDLE;
            count_d = 16'h0000;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (ss_p) state_d = RUN;
                end
                RUN: begin
                    // A tick coinciding with a pause still lands; saturation wins over pause.
                    if (ss_p) state_d = PAUSE;
                    if (tick) begin
                        presc_d = '0;
                        if (count_q == COUNT_MAX) state_d = HALT;
                        else                      count_d = bcd_inc(count_q);
                    end else begin
                        presc_d = presc_q + TICK_W'(1);
                    end
                end
                PAUSE: begin
                    if (ss_p) state_d = RUN;
                end
                HALT: begin
                    state_d = HALT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= 16'h0000;
            presc_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            running_q  <= (state_d == RUN);
            overflow_q <= (state_d == HALT);
        end
    end

    // Scan divider runs regardless of FSM activity; only reset stops it.
    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            clk_1k_d   = ~clk_1k_q;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            clk_1k_d   = clk_1k_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            clk_1k_q   <= 1'b0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            clk_1k_q   <= clk_1k_d;
        end
    end

    assign count     = count_q;
    assign clk_1k    = clk_1k_q;
    assign running   = running_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench: one instance at TICK_DIV=10 for sequencing and timing,
// one at TICK_DIV=2 to reach saturation quickly. Expected output changes carry a cycle gap.
module tb_stopwatch_counter;

    logic        clk;
    logic        rst_n, rst_n_f;
    logic        btn_ss, btn_clr, btn_ss_f, btn_clr_f;
    logic [15:0] count, count_f;
    logic        clk_1k, clk_1k_f;
    logic        running, running_f;
    logic        overflow, overflow_f;
    logic [1:0]  state_dbg, state_dbg_f;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int scan_seen = 0;
    int tog_f = 0;

    // Entry layout: [33:18] cycles since previous output change (0 = any), [17:0] {overflow, running, count}
    logic [33:0] exp_q[$];
    logic [33:0] exp_f_q[$];

    stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(100)) dut (
        .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr),
        .count(count), .clk_1k(clk_1k), .running(running), .overflow(overflow),
        .state_dbg(state_dbg)
    );

    stopwatch_counter #(.CLK_HZ(200), .TICK_HZ(100), .SCAN_HZ(20)) dut_f (
        .clk(clk), .rst_n(rst_n_f), .btn_ss(btn_ss_f), .btn_clr(btn_clr_f),
        .count(count_f), .clk_1k(clk_1k_f), .running(running_f), .overflow(overflow_f),
        .state_dbg(state_dbg_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic void push_m(input logic ovf, input logic run, input logic [15:0] cnt, input int gap);
        exp_q.push_back({16'(gap), ovf, run, cnt});
    endfunction

    function automatic void push_f(input logic ovf, input logic run, input logic [15:0] cnt, input int gap);
        exp_f_q.push_back({16'(gap), ovf, run, cnt});
    endfunction

    initial begin : mon_main
        logic [17:0] obs, prev;
        logic [33:0] e;
        int last;
        prev = '0;
        last = 0;
        forever begin
            @(negedge clk);
            obs = {overflow, running, count};
            if (obs !== prev) begin
                if (exp_q.size() == 0) begin
                    check("main_unexpected_change", 32'(obs), 32'(prev));
                end else begin
                    e = exp_q.pop_front();
                    check("main_out", 32'(obs), 32'(e[17:0]));
                    if (e[33:18] != 16'd0) check("main_gap", cyc - last, 32'(e[33:18]));
                end
                prev = obs;
                last = cyc;
            end
        end
    end

    initial begin : mon_fast
        logic [17:0] obs, prev;
        logic [33:0] e;
        int last;
        prev = '0;
        last = 0;
        forever begin
            @(negedge clk);
            obs = {overflow_f, running_f, count_f};
            if (obs !== prev) begin
                if (exp_f_q.size() == 0) begin
                    check("fast_unexpected_change", 32'(obs), 32'(prev));
                end else begin
                    e = exp_f_q.pop_front();
                    check("fast_out", 32'(obs), 32'(e[17:0]));
                    if (e[33:18] != 16'd0) check("fast_gap", cyc - last, 32'(e[33:18]));
                end
                prev = obs;
                last = cyc;
            end
        end
    end

    // Every clk_1k level must last exactly 5 clk (period 10, 50% duty) outside reset.
    initial begin : mon_scan
        logic prev;
        int last;
        prev = 1'b0;
        last = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = -1;
                prev = clk_1k;
            end else if (clk_1k !== prev) begin
                if (last >= 0) begin
                    check("scan_half_period", cyc - last, 5);
                    scan_seen++;
                end
                last = cyc;
                prev = clk_1k;
            end
        end
    end

    initial forever begin
        @(clk_1k_f);
        if (rst_n_f) tog_f++;
    end

    task automatic main_seq();
        // Start with a 50-clk hold: one start only, count every 10 clk, clear lands on a tick.
        push_m(0, 1, 16'h0000, 0);
        for (int i = 1; i <= 10; i++) push_m(0, 1, bcd(i), 10);
        push_m(0, 0, 16'h0000, 10);
        btn_ss = 1'b1; wait_n(50); btn_ss = 1'b0; wait_n(60);
        btn_clr = 1'b1; wait_n(4); btn_clr = 1'b0; wait_n(10);

        // Pause 4 clk after 0003, resume keeps partial interval, then ss+clr together at 0042.
        push_m(0, 1, 16'h0000, 0);
        push_m(0, 1, 16'h0001, 10);
        push_m(0, 1, 16'h0002, 10);
        push_m(0, 1, 16'h0003, 10);
        push_m(0, 0, 16'h0003, 4);
        push_m(0, 1, 16'h0003, 24);
        push_m(0, 1, 16'h0004, 6);
        for (int i = 5; i <= 42; i++) push_m(0, 1, bcd(i), 10);
        push_m(0, 0, 16'h0000, 6);
        btn_ss = 1'b1; wait_n(4); btn_ss = 1'b0; wait_n(30);
        btn_ss = 1'b1; wait_n(4); btn_ss = 1'b0; wait_n(20);
        btn_ss = 1'b1; wait_n(4); btn_ss = 1'b0; wait_n(388);
        btn_ss = 1'b1; btn_clr = 1'b1; wait_n(4);
        btn_ss = 1'b0; btn_clr = 1'b0; wait_n(50);
        check("clr_prio_state", 32'(state_dbg), 32'd0);

        // Asynchronous reset in the middle of a run at 0002.
        push_m(0, 1, 16'h0000, 0);
        push_m(0, 1, 16'h0001, 10);
        push_m(0, 1, 16'h0002, 10);
        push_m(0, 0, 16'h0000, 0);
        btn_ss = 1'b1; wait_n(4); btn_ss = 1'b0; wait_n(24);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'h0000);
        check("async_rst_clk_1k", 32'(clk_1k), 32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        check("async_rst_state", 32'(state_dbg), 32'd0);
        wait_n(3);
        rst_n = 1'b1;
        wait_n(40);
    endtask

    task automatic fast_seq();
        // 9999 ticks at 2 clk each, saturate into HALT, ss ignored, clear recovers.
        push_f(0, 1, 16'h0000, 0);
        for (int i = 1; i <= 9999; i++) push_f(0, 1, bcd(i), 2);
        push_f(1, 0, 16'h9999, 2);
        push_f(0, 0, 16'h0000, 0);
        btn_ss_f = 1'b1; wait_n(4); btn_ss_f = 1'b0; wait_n(20020);
        btn_ss_f = 1'b1; wait_n(4); btn_ss_f = 1'b0; wait_n(20);
        check("halt_ignores_ss", 32'(state_dbg_f), 32'd3);
        btn_clr_f = 1'b1; wait_n(4); btn_clr_f = 1'b0; wait_n(10);
        check("halt_clear_state", 32'(state_dbg_f), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rst_n_f = 1'b0;
        btn_ss = 1'b0; btn_clr = 1'b0; btn_ss_f = 1'b0; btn_clr_f = 1'b0;
        #23;
        check("reset_count", 32'(count), 32'h0000);
        check("reset_clk_1k", 32'(clk_1k), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rst_n_f = 1'b1;
        wait_n(3);
        fork
            main_seq();
            fast_seq();
        join
        check("main_queue_drained", exp_q.size(), 0);
        check("fast_queue_drained", exp_f_q.size(), 0);
        check("scan_active", 32'(scan_seen > 1000), 32'd1);
        check("fast_scan_active", 32'(tog_f > 100), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
